// File: rtl/collatz_sweep_ctrl.sv
// Sweeps a seed range through one Collatz engine over its start/busy handshake,
// counts the steps of each trajectory and keeps the seed with the longest one.
module collatz_sweep_ctrl #(
  parameter int W       = 16,
  parameter int SW      = 10,
  parameter int TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  best_seed,
  output logic [SW-1:0] best_steps,
  output logic [W-1:0]  cur_seed,
  output logic          eng_st,
  output logic [W-1:0]  eng_co,
  input  logic          eng_bs,
  input  logic [W-1:0]  eng_x
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LAUNCH  = 3'd1;
  localparam logic [2:0] WAIT_BS = 3'd2;
  localparam logic [2:0] RUN     = 3'd3;
  localparam logic [2:0] NEXT    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Last WAIT_BS count before abort, chosen so DONE lands TIMEOUT cycles after eng_st.
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT >= 2) ? (TIMEOUT - 2) : 0);
  localparam logic [SW-1:0] STEP_MAX = {SW{1'b1}};
  localparam logic [W-1:0]  SEED_ONE = W'(1);

  logic [2:0]    state_r;
  logic [2:0]    state_nx_s;
  logic [W-1:0]  hi_r;
  logic [W-1:0]  cur_seed_r;
  logic [W-1:0]  best_seed_r;
  logic [W-1:0]  eng_co_r;
  logic [SW-1:0] steps_r;
  logic [SW-1:0] best_steps_r;
  logic [TW-1:0] tmo_cnt_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic          eng_st_r;
  logic [W-1:0]  first_seed_s;
  logic [W-1:0]  launch_seed_s;
  logic          launch_s;
  logic          tmo_hit_s;
  logic          eng_x_unused_s;

  assign first_seed_s   = (lo == {W{1'b0}}) ? SEED_ONE : lo;
  assign tmo_hit_s      = (tmo_cnt_r >= TMO_LAST);
  assign eng_x_unused_s = ^eng_x;

  // Next-state decode; also works out which seed the next LAUNCH will hold.
  always_comb begin
    state_nx_s    = state_r;
    launch_seed_s = cur_seed_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          launch_seed_s = first_seed_s;
          if (first_seed_s > hi) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = LAUNCH;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      LAUNCH: begin
        if (cur_seed_r == SEED_ONE) begin
          state_nx_s = NEXT;
        end else begin
          state_nx_s = WAIT_BS;
        end
      end
      WAIT_BS: begin
        if (eng_bs) begin
          state_nx_s = RUN;
        end else if (tmo_hit_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = WAIT_BS;
        end
      end
      RUN: begin
        if (eng_bs) begin
          if (steps_r == STEP_MAX) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = NEXT;
        end
      end
      NEXT: begin
        if (cur_seed_r == hi_r) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s    = LAUNCH;
          launch_seed_s = cur_seed_r + SEED_ONE;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Seed 1 is handled without the engine, so it never raises eng_st.
  assign launch_s = (state_nx_s == LAUNCH) && (launch_seed_s != SEED_ONE);

  // State, handshake, step counting and best-seed tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      hi_r         <= {W{1'b0}};
      cur_seed_r   <= {W{1'b0}};
      best_seed_r  <= {W{1'b0}};
      eng_co_r     <= {W{1'b0}};
      steps_r      <= {SW{1'b0}};
      best_steps_r <= {SW{1'b0}};
      tmo_cnt_r    <= {TW{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      eng_st_r     <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      eng_st_r <= launch_s;
      done_r   <= (state_r == DONE);
      if (launch_s) begin
        eng_co_r <= launch_seed_s;
      end else begin
        eng_co_r <= eng_co_r;
      end
      if (state_nx_s == LAUNCH) begin
        cur_seed_r <= launch_seed_s;
      end else begin
        cur_seed_r <= cur_seed_r;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            hi_r         <= hi;
            cur_seed_r   <= first_seed_s;
            best_seed_r  <= {W{1'b0}};
            best_steps_r <= {SW{1'b0}};
            err_r        <= 1'b0;
            busy_r       <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        LAUNCH: begin
          // Seed 1 scores zero steps and can never beat the cleared best.
          tmo_cnt_r <= {TW{1'b0}};
          steps_r   <= {SW{1'b0}};
        end
        WAIT_BS: begin
          if (eng_bs) begin
            steps_r <= SW'(1);
          end else if (tmo_hit_s) begin
            err_r <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        RUN: begin
          if (eng_bs) begin
            if (steps_r == STEP_MAX) begin
              err_r <= 1'b1;
            end else begin
              steps_r <= steps_r + SW'(1);
            end
          end else if (steps_r > best_steps_r) begin
            best_seed_r  <= cur_seed_r;
            best_steps_r <= steps_r;
          end else begin
            best_steps_r <= best_steps_r;
          end
        end
        NEXT: begin
          steps_r <= {SW{1'b0}};
        end
        DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign best_seed  = best_seed_r;
  assign best_steps = best_steps_r;
  assign cur_seed   = cur_seed_r;
  assign eng_st     = eng_st_r;
  assign eng_co     = eng_co_r;

endmodule
